// File: rtl/mmss_countdown_timer.sv
// BCD mm:ss countdown timer with one-second prescaler, start/pause/load control,
// optional auto-reload after expiry, and expiry/low-time warning flags.
module mmss_countdown_timer #(
  parameter int CLK_DIV   = 100000000,
  parameter int START_MIN = 1,
  parameter int START_SEC = 0,
  parameter int WARN_SEC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic       auto_reload,
  input  logic [3:0] load_m2,
  input  logic [3:0] load_m1,
  input  logic [2:0] load_s2,
  input  logic [3:0] load_s1,
  output logic [3:0] m2,
  output logic [3:0] m1,
  output logic [2:0] s2,
  output logic [3:0] s1,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       expire_pulse,
  output logic       warn
);

  localparam int PW = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  localparam logic [3:0] RST_M2 = 4'(START_MIN / 10);
  localparam logic [3:0] RST_M1 = 4'(START_MIN % 10);
  localparam logic [2:0] RST_S2 = 3'(START_SEC / 10);
  localparam logic [3:0] RST_S1 = 4'(START_SEC % 10);

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    m2_q, m2_d, m1_q, m1_d, s1_q, s1_d;
  logic [2:0]    s2_q, s2_d;
  logic [3:0]    pm2_q, pm2_d, pm1_q, pm1_d, ps1_q, ps1_d;
  logic [2:0]    ps2_q, ps2_d;
  logic          pulse_q, pulse_d;

  logic [3:0] cm2, cm1, cs1;
  logic [2:0] cs2;
  logic       dig_zero, dig_one;
  logic [6:0] secs;

  assign cm2 = (load_m2 > 4'd9) ? 4'd9 : load_m2;
  assign cm1 = (load_m1 > 4'd9) ? 4'd9 : load_m1;
  assign cs2 = (load_s2 > 3'd5) ? 3'd5 : load_s2;
  assign cs1 = (load_s1 > 4'd9) ? 4'd9 : load_s1;

  assign dig_zero = (m2_q == 4'd0) && (m1_q == 4'd0) && (s2_q == 3'd0) && (s1_q == 4'd0);
  assign dig_one  = (m2_q == 4'd0) && (m1_q == 4'd0) && (s2_q == 3'd0) && (s1_q == 4'd1);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    m2_d = m2_q;  m1_d = m1_q;  s2_d = s2_q;  s1_d = s1_q;
    pm2_d = pm2_q; pm1_d = pm1_q; ps2_d = ps2_q; ps1_d = ps1_q;
    pulse_d = 1'b0;

    if (load) begin
      pm2_d = cm2; pm1_d = cm1; ps2_d = cs2; ps1_d = cs1;
      m2_d  = cm2; m1_d  = cm1; s2_d  = cs2; s1_d  = cs1;
      state_d = S_IDLE;
      pre_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !dig_zero) begin
            state_d = S_RUN;
            pre_d   = '0;
          end
        end
        S_PAUSED: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (pre_q != PRE_MAX) begin
            pre_d = pre_q + 1'b1;
          end else begin
            pre_d = '0;
            // 00:00 while running only occurs after an auto-reload expiry
            if (dig_one) begin
              m2_d = 4'd0; m1_d = 4'd0; s2_d = 3'd0; s1_d = 4'd0;
              pulse_d = 1'b1;
              if (!auto_reload) state_d = S_EXPIRED;
            end else if (dig_zero) begin
              if (auto_reload) begin
                m2_d = pm2_q; m1_d = pm1_q; s2_d = ps2_q; s1_d = ps1_q;
              end else begin
                state_d = S_EXPIRED;
              end
            end else if (s1_q != 4'd0) begin
              s1_d = s1_q - 4'd1;
            end else begin
              s1_d = 4'd9;
              if (s2_q != 3'd0) begin
                s2_d = s2_q - 3'd1;
              end else begin
                s2_d = 3'd5;
                if (m1_q != 4'd0) begin
                  m1_d = m1_q - 4'd1;
                end else begin
                  m1_d = 4'd9;
                  m2_d = m2_q - 4'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      pulse_q <= 1'b0;
      m2_q  <= RST_M2; m1_q  <= RST_M1; s2_q  <= RST_S2; s1_q  <= RST_S1;
      pm2_q <= RST_M2; pm1_q <= RST_M1; ps2_q <= RST_S2; ps1_q <= RST_S1;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
      m2_q  <= m2_d;  m1_q  <= m1_d;  s2_q  <= s2_d;  s1_q  <= s1_d;
      pm2_q <= pm2_d; pm1_q <= pm1_d; ps2_q <= ps2_d; ps1_q <= ps1_d;
    end
  end

  assign secs = 7'(s2_q) * 7'd10 + 7'(s1_q);

  assign m2 = m2_q;
  assign m1 = m1_q;
  assign s2 = s2_q;
  assign s1 = s1_q;
  assign running      = (state_q == S_RUN);
  assign paused       = (state_q == S_PAUSED);
  assign expired      = (state_q == S_EXPIRED);
  assign expire_pulse = pulse_q;
  assign warn = (running || paused) && (m2_q == 4'd0) && (m1_q == 4'd0) &&
                (secs != 7'd0) && (secs <= 7'(WARN_SEC)) && (WARN_SEC != 0);

endmodule

// File: tb/tb_mmss_countdown_timer.sv
// Table-driven bench for mmss_countdown_timer (CLK_DIV=4, preset 01:00, warn at 10 s).
module tb_mmss_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, start, pause, load, auto_reload;
  logic [3:0] load_m2, load_m1, load_s1;
  logic [2:0] load_s2;
  logic [3:0] m2, m1, s1;
  logic [2:0] s2;
  logic       running, paused, expired, expire_pulse, warn;

  always #5 clk = ~clk;

  mmss_countdown_timer #(
    .CLK_DIV(4), .START_MIN(1), .START_SEC(0), .WARN_SEC(10)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .load(load),
    .auto_reload(auto_reload), .load_m2(load_m2), .load_m1(load_m1),
    .load_s2(load_s2), .load_s1(load_s1), .m2(m2), .m1(m1), .s2(s2), .s1(s1),
    .running(running), .paused(paused), .expired(expired),
    .expire_pulse(expire_pulse), .warn(warn)
  );

  // flags packed as {running, paused, expired, expire_pulse, warn}
  typedef struct {
    string       name;
    logic        st, pa, ld, ar;
    logic [14:0] ldig;
    int unsigned wait_cyc;
    logic [14:0] exp_dig;
    logic [4:0]  exp_flags;
  } vec_t;

  typedef struct {
    string       name;
    logic [14:0] exp_dig;
    logic [4:0]  exp_flags;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [14:0] dg(int m, int s);
    return {4'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic void add(string n, logic st, logic pa, logic ld, logic ar,
                              logic [14:0] ldig, int unsigned w,
                              logic [14:0] ed, logic [4:0] ef);
    vec_t v;
    v.name = n; v.st = st; v.pa = pa; v.ld = ld; v.ar = ar; v.ldig = ldig;
    v.wait_cyc = w; v.exp_dig = ed; v.exp_flags = ef;
    tbl.push_back(v);
  endfunction

  task automatic check(string n, logic [14:0] ed, logic [4:0] ef);
    logic [14:0] ad;
    logic [4:0]  af;
    ad = {m2, m1, s2, s1};
    af = {running, paused, expired, expire_pulse, warn};
    n_checks++;
    if (ad === ed) n_pass++;
    else $display("FAIL %s digits: got %0d%0d:%0d%0d want %0d%0d:%0d%0d", n,
                  ad[14:11], ad[10:7], ad[6:4], ad[3:0], ed[14:11], ed[10:7], ed[6:4], ed[3:0]);
    n_checks++;
    if (af === ef) n_pass++;
    else $display("FAIL %s flags(run,pau,exp,pulse,warn): got %b want %b", n, af, ef);
  endtask

  task automatic drive_idle(logic ar);
    start = 1'b0; pause = 1'b0; load = 1'b0; auto_reload = ar;
    {load_m2, load_m1, load_s2, load_s1} = '0;
  endtask

  initial begin
    sb_t e;
    // name, start, pause, load, auto, load digits, extra cycles, exp digits, exp flags
    add("start",        1, 0, 0, 0, '0, 0,  dg(1, 0),   5'b10000);
    add("first_tick",   0, 0, 0, 0, '0, 3,  dg(0, 59),  5'b10000);
    add("ten_ticks",    0, 0, 0, 0, '0, 39, dg(0, 49),  5'b10000);
    add("pre_to_2",     0, 0, 0, 0, '0, 1,  dg(0, 49),  5'b10000);
    add("paused10",     0, 1, 0, 0, '0, 9,  dg(0, 49),  5'b01000);
    add("resume",       1, 0, 0, 0, '0, 0,  dg(0, 49),  5'b10000);
    add("resume_p3",    0, 0, 0, 0, '0, 0,  dg(0, 49),  5'b10000);
    add("resume_tick",  0, 0, 0, 0, '0, 0,  dg(0, 48),  5'b10000);
    add("both_in_run",  1, 1, 0, 0, '0, 0,  dg(0, 48),  5'b01000);
    add("both_in_pau",  1, 1, 0, 0, '0, 0,  dg(0, 48),  5'b10000);
    add("load_clamp",   1, 0, 1, 0, {4'd12, 4'd15, 3'd7, 4'd11}, 0, dg(99, 59), 5'b00000);
    add("load_zero",    0, 0, 1, 0, dg(0, 0), 0, dg(0, 0),  5'b00000);
    add("start_zero",   1, 0, 0, 0, '0, 2,  dg(0, 0),   5'b00000);
    add("load_02",      0, 0, 1, 0, dg(0, 2), 0, dg(0, 2),  5'b00000);
    add("start_02",     1, 0, 0, 0, '0, 0,  dg(0, 2),   5'b10001);
    add("at_01",        0, 0, 0, 0, '0, 3,  dg(0, 1),   5'b10001);
    add("expire",       0, 0, 0, 0, '0, 3,  dg(0, 0),   5'b00110);
    add("pulse_gone",   0, 0, 0, 0, '0, 0,  dg(0, 0),   5'b00100);
    add("start_exp",    1, 0, 0, 0, '0, 4,  dg(0, 0),   5'b00100);
    add("ar_load",      0, 0, 1, 1, dg(0, 2), 0, dg(0, 2),  5'b00000);
    add("ar_start",     1, 0, 0, 1, '0, 0,  dg(0, 2),   5'b10001);
    add("ar_01",        0, 0, 0, 1, '0, 3,  dg(0, 1),   5'b10001);
    add("ar_00_pulse",  0, 0, 0, 1, '0, 3,  dg(0, 0),   5'b10010);
    add("ar_00_hold",   0, 0, 0, 1, '0, 0,  dg(0, 0),   5'b10000);
    add("ar_reload",    0, 0, 0, 1, '0, 2,  dg(0, 2),   5'b10001);
    add("ar_01b",       0, 0, 0, 1, '0, 3,  dg(0, 1),   5'b10001);
    add("ar_00_pulse2", 0, 0, 0, 1, '0, 3,  dg(0, 0),   5'b10010);
    add("ar_drop",      0, 0, 0, 0, '0, 3,  dg(0, 0),   5'b00100);
    add("load_12",      0, 0, 1, 0, dg(0, 12), 0, dg(0, 12), 5'b00000);
    add("start_12",     1, 0, 0, 0, '0, 0,  dg(0, 12),  5'b10000);
    add("warn_11",      0, 0, 0, 0, '0, 3,  dg(0, 11),  5'b10000);
    add("warn_10",      0, 0, 0, 0, '0, 3,  dg(0, 10),  5'b10001);
    add("warn_09",      0, 0, 0, 0, '0, 3,  dg(0, 9),   5'b10001);
    add("warn_00",      0, 0, 0, 0, '0, 35, dg(0, 0),   5'b00110);

    reset = 1'b0;
    drive_idle(1'b0);
    // inputs asserted during reset must be ignored
    start = 1'b1; load = 1'b1; load_m2 = 4'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", dg(1, 0), 5'b00000);
    reset = 1'b1;
    drive_idle(1'b0);

    foreach (tbl[i]) begin
      start = tbl[i].st; pause = tbl[i].pa; load = tbl[i].ld; auto_reload = tbl[i].ar;
      {load_m2, load_m1, load_s2, load_s1} = tbl[i].ldig;
      e.name = tbl[i].name; e.exp_dig = tbl[i].exp_dig; e.exp_flags = tbl[i].exp_flags;
      sbq.push_back(e);
      @(posedge clk);
      @(negedge clk);
      drive_idle(tbl[i].ar);
      for (int unsigned c = 0; c < tbl[i].wait_cyc; c++) @(negedge clk);
      e = sbq.pop_front();
      check(e.name, e.exp_dig, e.exp_flags);
    end

    // load takes priority over a simultaneous start while running
    load_m2 = 4'd0; load_m1 = 4'd0; load_s2 = 3'd3; load_s1 = 4'd0; load = 1'b1;
    @(posedge clk); @(negedge clk);
    drive_idle(1'b0); start = 1'b1;
    @(posedge clk); @(negedge clk);
    load = 1'b1; start = 1'b1; {load_m2, load_m1, load_s2, load_s1} = dg(0, 45);
    @(posedge clk); @(negedge clk);
    check("load_in_run", dg(0, 45), 5'b00000);
    drive_idle(1'b0);

    // synchronous reset mid-run restores preset and IDLE
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    check("reset_in_run", dg(1, 0), 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
